// File: rtl/acc_feed_ctrl.sv
// acc_feed_ctrl: Avalon-MM slave that buffers HPS-written data words in a FIFO
// and streams exactly LENGTH of them to the accelerator over valid/ready,
// flagging the final word. Exposes busy/done/overflow status for readback.
// Optional build macro: ACC_FEED_IRQ_EN (sticky job-complete interrupt).
module acc_feed_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [2:0]        address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state, state_next;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [LW-1:0]      level;
    logic [LEN_W-1:0]   length, remaining;
    logic               overflow;

    logic wr_en, rd_en, ctrl_wr, start, clear, push, pop, push_acc;
    logic full, empty, launch;
    logic [31:0] len_ext, status_word;
    logic [7:0]  level_ext;

    // Bus decode: CLEAR outranks START and any DATA push in the same cycle.
    assign wr_en    = chipselect && write;
    assign rd_en    = chipselect && read;
    assign ctrl_wr  = wr_en && (address == 3'd0);
    assign start    = ctrl_wr && writedata[0];
    assign clear    = ctrl_wr && writedata[1];
    assign push     = wr_en && (address == 3'd3) && !clear;
    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign pop      = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_acc = push && (!full || pop);
    assign launch   = start && !clear && (state != S_RUN) && (length != '0);
    assign out_data = mem[rd_ptr];

    // Next-state and stream/status outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = (state == S_RUN);
        done       = (state == S_DONE);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_next = (length != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                out_valid = !empty;
                out_last  = !empty && (remaining == LEN_W'(1));
                if (out_valid && out_ready && out_last) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
        if (clear) state_next = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Job length register and remaining-word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            length    <= '0;
            remaining <= '0;
        end else begin
            if (wr_en && (address == 3'd1)) length <= writedata[LEN_W-1:0];
            if (clear)       remaining <= '0;
            else if (launch) remaining <= length;
            else if (pop)    remaining <= remaining - LEN_W'(1);
        end
    end

    // FIFO pointers, level and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + AW'(1);
            if (pop)      rd_ptr <= rd_ptr + AW'(1);
            if (push_acc && !pop)      level <= level + LW'(1);
            else if (!push_acc && pop) level <= level - LW'(1);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: the array is reset because out_data is read straight from it and must be 0 after reset.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_acc) begin
            mem[wr_ptr] <= writedata[DATA_W-1:0];
        end
    end

    // Zero-extended register views for readback.
    always_comb begin
        len_ext                 = '0;
        len_ext[LEN_W-1:0]      = length;
        level_ext               = '0;
        level_ext[LW-1:0]       = level;
        status_word             = '0;
        status_word[0]          = busy;
        status_word[1]          = done;
        status_word[2]          = full;
        status_word[3]          = empty;
        status_word[4]          = overflow;
        status_word[15:8]       = level_ext;
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            case (address)
                3'd1:    readdata <= len_ext;
                3'd2:    readdata <= status_word;
                default: readdata <= '0;
            endcase
        end
    end

`ifdef ACC_FEED_IRQ_EN
    logic irq_q, irq_set, irq_clr;
    assign irq_set = (state != S_DONE) && (state_next == S_DONE);
    assign irq_clr = (rd_en && (address == 3'd2)) || clear || start;

    // Sticky interrupt: set on entry to DONE, which wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (reset)        irq_q <= 1'b0;
        else if (irq_set) irq_q <= 1'b1;
        else if (irq_clr) irq_q <= 1'b0;
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
